fb_arbiter: RTL and testbench
=============================

Name: fb_arbiter

Overview:
- Single-port arbiter and sequencer for the 160x120, 12-bit frame-buffer RAM: 19200 words, synchronous read, write-first, one-cycle read latency.
- Shares the one RAM port between three requesters: VGA scan-out reads, paint brush writes, and eyedropper reads.
- Contains a clear-screen engine that fills the whole buffer with one colour.
- Sits between the drawing/VGA logic and the frame-buffer RAM instance.

Parameters:
- DEPTH, 19200, number of frame-buffer words (160*120).
- AW, 15, address width.
- DW, 12, pixel width (4:4:4 RGB).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- disp_req  in  1  VGA read request this cycle.
- disp_addr  in  AW  VGA read address.
- disp_rdata  out  DW  VGA read data; wired to ram_rd.
- disp_rvalid  out  1  disp_rdata valid; registered.
- pw_valid  in  1  paint write request.
- pw_ready  out  1  paint write accepted this cycle.
- pw_addr  in  AW  paint write address.
- pw_data  in  DW  paint write colour.
- er_valid  in  1  eyedropper read request.
- er_ready  out  1  eyedropper read accepted this cycle.
- er_addr  in  AW  eyedropper read address.
- er_rdata  out  DW  eyedropper data; wired to ram_rd.
- er_rvalid  out  1  er_rdata valid; registered.
- clr_start  in  1  start-clear pulse.
- clr_color  in  DW  fill colour, sampled on accepted clr_start.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse after the last clear write.
- ram_we  out  1  RAM write enable.
- ram_a  out  AW  RAM address.
- ram_wd  out  DW  RAM write data.
- ram_rd  in  DW  RAM read data, valid the cycle after the address is presented.

Behaviour:
- Arbitration is combinational per cycle. Fixed priority: display > clear engine > paint write > eyedropper. Exactly one requester owns the port each cycle.
- Display: never stalled. ram_a=disp_addr, ram_we=0. disp_rvalid=1 on the following cycle.
- Clear engine: owns the port when clr_busy=1 and disp_req=0.
  - ram_we=1, ram_a=clr_ptr, ram_wd=latched colour.
  - clr_ptr increments only on cycles it owns the port.
- Paint write: pw_ready = pw_valid & !disp_req & !clr_busy & !reset. On a ready cycle, ram_we=1, ram_a=pw_addr, ram_wd=pw_data.
- Eyedropper: er_ready = er_valid & !disp_req & !clr_busy & !pw_valid & !reset. er_rvalid=1 on the following cycle. Starvation under continuous pw_valid is accepted.
- Idle cycles (no owner): ram_we=0, ram_a=0, ram_wd=0.
- Out-of-range address (>= DEPTH):
  - Paint write: still handshaken (pw_ready=1), but ram_we forced 0.
  - Eyedropper read: accepted; er_rdata forced 0 while er_rvalid is high.
  - Display read: forced 0 the same way.
- A write cycle never asserts any rvalid, even though the RAM updates rd (write-first).
- Clear FSM, states IDLE and CLEAR:
  - IDLE: clr_start=1 latches clr_color, sets clr_ptr=0, goes to CLEAR. clr_busy=1 from the next cycle.
  - CLEAR: on an owned cycle with clr_ptr==DEPTH-1, write the last word, go to IDLE. clr_busy falls and clr_done pulses high for exactly one cycle on the next cycle.
  - clr_start during CLEAR is ignored; the colour is unchanged.
  - Unstalled clear: clr_busy high for exactly DEPTH cycles.
  - Each display-owned cycle during CLEAR extends the clear by one cycle.
- Reset (synchronous, any state, including mid-clear):
  - FSM goes to IDLE; clr_ptr=0, colour latch=0.
  - clr_busy=0, clr_done=0, disp_rvalid=0, er_rvalid=0.
  - During reset: ram_we=0, pw_ready=0, er_ready=0.
  - A partially cleared buffer is left as is; no resumption after reset.
- All registered state updates on posedge clk only.

Test Plan:
- Reset then disp_req=1, disp_addr=5 with RAM[5]=0xABC -> ram_a=5 same cycle; next cycle disp_rvalid=1, disp_rdata=0xABC.
- pw_valid with pw_addr=100, pw_data=0xF00, then er_valid with er_addr=100 -> pw_ready=1, ram_we=1; eyedropper next cycle returns er_rdata=0xF00 with er_rvalid=1.
- pw_valid and disp_req together -> pw_ready=0, ram_we=0. After disp_req drops, the write completes; pw_data is not lost.
- clr_start with clr_color=0x0F0, no other traffic -> clr_busy high 19200 cycles, clr_done one pulse. RAM[0] and RAM[19199] = 0x0F0; pw_ready stays 0 throughout.
- Clear with disp_req asserted on 10 scattered cycles, plus a second clr_start with 0x00F mid-clear -> busy lasts 19210 cycles; all words 0x0F0.
- reset asserted at clr_ptr=500 -> next cycle clr_busy=0, clr_done=0. RAM[0..499] = new colour, RAM[500..] unchanged; a new clr_start restarts at address 0.

Source files
------------

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter: display > clear engine > paint write > eyedropper,
// with a clear-screen engine that fills every word with one latched colour.
module fb_arbiter #(
    parameter int DEPTH = 19200,
    parameter int AW    = 15,
    parameter int DW    = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic [DW-1:0] disp_rdata,
    output logic          disp_rvalid,
    input  logic          pw_valid,
    output logic          pw_ready,
    input  logic [AW-1:0] pw_addr,
    input  logic [DW-1:0] pw_data,
    input  logic          er_valid,
    output logic          er_ready,
    input  logic [AW-1:0] er_addr,
    output logic [DW-1:0] er_rdata,
    output logic          er_rvalid,
    input  logic          clr_start,
    input  logic [DW-1:0] clr_color,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          ram_we,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_wd,
    input  logic [DW-1:0] ram_rd
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t        state, state_next;
    logic [AW-1:0] clr_ptr;
    logic [DW-1:0] clr_col;
    logic          clr_own;
    logic          clr_last;
    logic          disp_oor;
    logic          er_oor;

    function automatic logic in_range(input logic [AW-1:0] a);
        return a <= LAST;
    endfunction

    assign clr_busy   = (state == CLEAR);
    assign clr_last   = (clr_ptr == LAST);
    // Out-of-range reads return zero while their rvalid is high.
    assign disp_rdata = disp_oor ? '0 : ram_rd;
    assign er_rdata   = er_oor   ? '0 : ram_rd;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        clr_own    = 1'b0;
        pw_ready   = 1'b0;
        er_ready   = 1'b0;
        ram_we     = 1'b0;
        ram_a      = '0;
        ram_wd     = '0;

        if (disp_req) begin
            ram_a = disp_addr;
        end else if (reset) begin
            // Reset holds every non-display requester off the port.
        end else if (clr_busy) begin
            clr_own = 1'b1;
            ram_we  = 1'b1;
            ram_a   = clr_ptr;
            ram_wd  = clr_col;
        end else if (pw_valid) begin
            pw_ready = 1'b1;
            ram_we   = in_range(pw_addr);
            ram_a    = pw_addr;
            ram_wd   = pw_data;
        end else if (er_valid) begin
            er_ready = 1'b1;
            ram_a    = er_addr;
        end

        case (state)
            IDLE:    if (clr_start) state_next = CLEAR;
            CLEAR:   if (clr_own && clr_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_ptr     <= '0;
            clr_col     <= '0;
            clr_done    <= 1'b0;
            disp_rvalid <= 1'b0;
            disp_oor    <= 1'b0;
            er_rvalid   <= 1'b0;
            er_oor      <= 1'b0;
        end else begin
            clr_done    <= clr_own && clr_last;
            disp_rvalid <= disp_req;
            disp_oor    <= disp_req && !in_range(disp_addr);
            er_rvalid   <= er_ready;
            er_oor      <= er_ready && !in_range(er_addr);
            if (state == IDLE && clr_start) begin
                clr_col <= clr_color;
                clr_ptr <= '0;
            end else if (clr_own) begin
                clr_ptr <= clr_ptr + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: behavioural RAM, vector table, randomized
// traffic against a priority/shadow-memory model, and directed clear sequences.
module tb_fb_arbiter;

    localparam int DEPTH = 19200;
    localparam int AW    = 15;
    localparam int DW    = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_rdata;
    logic          disp_rvalid;
    logic          pw_valid;
    logic          pw_ready;
    logic [AW-1:0] pw_addr;
    logic [DW-1:0] pw_data;
    logic          er_valid;
    logic          er_ready;
    logic [AW-1:0] er_addr;
    logic [DW-1:0] er_rdata;
    logic          er_rvalid;
    logic          clr_start;
    logic [DW-1:0] clr_color;
    logic          clr_busy;
    logic          clr_done;
    logic          ram_we;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_wd;
    logic [DW-1:0] ram_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
        .pw_valid(pw_valid), .pw_ready(pw_ready), .pw_addr(pw_addr), .pw_data(pw_data),
        .er_valid(er_valid), .er_ready(er_ready), .er_addr(er_addr), .er_rdata(er_rdata), .er_rvalid(er_rvalid),
        .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy), .clr_done(clr_done),
        .ram_we(ram_we), .ram_a(ram_a), .ram_wd(ram_wd), .ram_rd(ram_rd)
    );

    function automatic logic [DW-1:0] preload(int i);
        return (i == 5) ? 12'hABC : 12'((i * 37) ^ 'h5A5);
    endfunction

    // Behavioural frame-buffer RAM: synchronous read, write-first, garbage when out of range.
    logic [DW-1:0] mem [DEPTH];
    logic          preloaded = 1'b0;
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= preload(i);
            preloaded <= 1'b1;
        end else if (ram_we && int'(ram_a) < DEPTH) begin
            mem[ram_a] <= ram_wd;
        end
        ram_rd <= ram_we ? ram_wd : ((int'(ram_a) < DEPTH) ? mem[ram_a] : 12'hBAD);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end expected end");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        disp_req = 1'b0; disp_addr = '0;
        pw_valid = 1'b0; pw_addr = '0; pw_data = '0;
        er_valid = 1'b0; er_addr = '0;
        clr_start = 1'b0; clr_color = '0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return AW'(DEPTH + int'($urandom_range(0, 400)));
        return AW'($urandom_range(8, 71));
    endfunction

    function automatic int mem_mismatches(input int lo, input int hi, input logic [DW-1:0] v);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (mem[i] !== v) n++;
        return n;
    endfunction

    // Runs one clear from clr_start until clr_busy falls (or a cycle budget expires).
    task automatic run_clear(input logic [DW-1:0] color, input bit scatter, input int reset_at,
                             output int busy_n, output int done_n, output int pw_hits);
        busy_n = 0; done_n = 0; pw_hits = 0;
        pw_valid = 1'b1; pw_addr = AW'(DEPTH + 3); pw_data = 12'hFFF;
        clr_start = 1'b1; clr_color = color;
        tick;
        clr_start = 1'b0; clr_color = 12'h777;
        for (int n = 0; n < 25000; n++) begin
            if (clr_done) done_n++;
            if (!clr_busy) break;
            busy_n++;
            if (pw_ready) pw_hits++;
            disp_req  = scatter && (n % 1900 == 950);
            disp_addr = 15'd7;
            clr_start = scatter && (n == 5000);
            clr_color = clr_start ? 12'h00F : 12'h777;
            reset     = (n == reset_at);
            tick;
        end
        idle_inputs();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick;
            if (clr_done) done_n++;
        end
    endtask

    typedef struct {
        logic          disp, pw, er;
        logic [AW-1:0] da, pa, ea;
        logic [DW-1:0] pd;
        logic          e_pwr, e_err, e_we;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_wd;
        bit            chk_wd;
    } vec_t;

    vec_t vecs [9];

    logic          exp_drv, exp_erv, e_pwr, e_err, e_we;
    logic [DW-1:0] exp_dd, exp_ed;
    logic [AW-1:0] e_a;
    logic [DW-1:0] ref_mem [DEPTH];
    int            busy_n, done_n, pw_hits;

    initial begin
        idle_inputs();
        reset = 1'b1;
        pw_valid = 1'b1; pw_addr = 15'd10; er_valid = 1'b1; er_addr = 15'd11;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = preload(i);

        tick;
        check("reset_pw_ready", pw_ready, 0);
        check("reset_er_ready", er_ready, 0);
        check("reset_ram_we", ram_we, 0);
        tick;
        check("reset_clr_busy", clr_busy, 0);
        check("reset_clr_done", clr_done, 0);
        check("reset_disp_rvalid", disp_rvalid, 0);
        check("reset_er_rvalid", er_rvalid, 0);
        reset = 1'b0;
        idle_inputs();
        tick;

        // Randomized traffic against the priority rules and a shadow memory.
        exp_drv = 1'b0; exp_erv = 1'b0; exp_dd = '0; exp_ed = '0;
        for (int c = 0; c < 2000; c++) begin
            tick;
            check("rnd_disp_rvalid", disp_rvalid, exp_drv);
            if (exp_drv) check("rnd_disp_rdata", disp_rdata, exp_dd);
            check("rnd_er_rvalid", er_rvalid, exp_erv);
            if (exp_erv) check("rnd_er_rdata", er_rdata, exp_ed);
            disp_req = ($urandom_range(0, 9) < 3); disp_addr = rand_addr();
            pw_valid = ($urandom_range(0, 9) < 4); pw_addr = rand_addr(); pw_data = DW'($urandom);
            er_valid = ($urandom_range(0, 9) < 4); er_addr = rand_addr();
            #1;
            e_pwr = pw_valid && !disp_req;
            e_err = er_valid && !disp_req && !pw_valid;
            e_we  = e_pwr && int'(pw_addr) < DEPTH;
            e_a   = disp_req ? disp_addr : e_pwr ? pw_addr : e_err ? er_addr : '0;
            check("rnd_pw_ready", pw_ready, e_pwr);
            check("rnd_er_ready", er_ready, e_err);
            check("rnd_ram_we", ram_we, e_we);
            check("rnd_ram_a", ram_a, e_a);
            exp_drv = disp_req;
            exp_dd  = (int'(disp_addr) < DEPTH) ? ref_mem[disp_addr] : '0;
            exp_erv = e_err;
            exp_ed  = (int'(er_addr) < DEPTH) ? ref_mem[er_addr] : '0;
            if (e_we) ref_mem[pw_addr] = pw_data;
        end
        idle_inputs();
        tick;
        check("rnd_tail_disp_rvalid", disp_rvalid, exp_drv);
        check("rnd_tail_er_rvalid", er_rvalid, exp_erv);

        // Arbitration vector table (clear engine idle).
        vecs[0] = '{0,0,0, 15'd0,  15'd0,     15'd0,     12'h000, 0,0,0, 15'd0,     12'h000, 1};
        vecs[1] = '{1,0,0, 15'd33, 15'd0,     15'd0,     12'h000, 0,0,0, 15'd33,    12'h000, 1};
        vecs[2] = '{1,1,1, 15'd34, 15'd200,   15'd201,   12'h456, 0,0,0, 15'd34,    12'h000, 1};
        vecs[3] = '{0,1,0, 15'd0,  15'd200,   15'd0,     12'h456, 1,0,1, 15'd200,   12'h456, 1};
        vecs[4] = '{0,1,1, 15'd0,  15'd202,   15'd201,   12'h789, 1,0,1, 15'd202,   12'h789, 1};
        vecs[5] = '{0,0,1, 15'd0,  15'd0,     15'd201,   12'h000, 0,1,0, 15'd201,   12'h000, 1};
        vecs[6] = '{0,1,0, 15'd0,  15'd19200, 15'd0,     12'h321, 1,0,0, 15'd19200, 12'h000, 0};
        vecs[7] = '{0,1,0, 15'd0,  15'd19199, 15'd0,     12'h654, 1,0,1, 15'd19199, 12'h654, 1};
        vecs[8] = '{0,0,1, 15'd0,  15'd0,     15'd32767, 12'h000, 0,1,0, 15'd32767, 12'h000, 1};
        for (int v = 0; v < 9; v++) begin
            disp_req = vecs[v].disp; disp_addr = vecs[v].da;
            pw_valid = vecs[v].pw;   pw_addr = vecs[v].pa; pw_data = vecs[v].pd;
            er_valid = vecs[v].er;   er_addr = vecs[v].ea;
            #1;
            check($sformatf("vec%0d_pw_ready", v), pw_ready, vecs[v].e_pwr);
            check($sformatf("vec%0d_er_ready", v), er_ready, vecs[v].e_err);
            check($sformatf("vec%0d_ram_we", v), ram_we, vecs[v].e_we);
            check($sformatf("vec%0d_ram_a", v), ram_a, vecs[v].e_a);
            if (vecs[v].chk_wd) check($sformatf("vec%0d_ram_wd", v), ram_wd, vecs[v].e_wd);
            tick;
        end
        idle_inputs();
        tick;

        // Display read of a preloaded word, then an out-of-range display read.
        disp_req = 1'b1; disp_addr = 15'd5;
        #1;
        check("disp_ram_a", ram_a, 5);
        tick;
        disp_addr = 15'd19300;
        check("disp_rvalid", disp_rvalid, 1);
        check("disp_rdata", disp_rdata, 12'hABC);
        tick;
        disp_req = 1'b0;
        check("disp_oor_rvalid", disp_rvalid, 1);
        check("disp_oor_rdata", disp_rdata, 0);
        tick;

        // Paint then eyedropper on the same address.
        pw_valid = 1'b1; pw_addr = 15'd100; pw_data = 12'hF00;
        #1;
        check("paint_ready", pw_ready, 1);
        check("paint_we", ram_we, 1);
        tick;
        pw_valid = 1'b0; er_valid = 1'b1; er_addr = 15'd100;
        #1;
        check("eyedrop_ready", er_ready, 1);
        check("eyedrop_we", ram_we, 0);
        tick;
        er_valid = 1'b0;
        check("eyedrop_rvalid", er_rvalid, 1);
        check("eyedrop_rdata", er_rdata, 12'hF00);
        tick;

        // Paint stalled by display, completes once display drops.
        pw_valid = 1'b1; pw_addr = 15'd300; pw_data = 12'h123; disp_req = 1'b1; disp_addr = 15'd9;
        #1;
        check("stall_pw_ready", pw_ready, 0);
        check("stall_ram_we", ram_we, 0);
        tick;
        disp_req = 1'b0;
        #1;
        check("resume_pw_ready", pw_ready, 1);
        check("resume_ram_wd", ram_wd, 12'h123);
        tick;
        pw_valid = 1'b0;
        check("resume_disp_rvalid_write_cycle", disp_rvalid, 0);
        check("resume_er_rvalid_write_cycle", er_rvalid, 0);
        check("resume_mem300", mem[300], 12'h123);

        // Clear stretched by ten display cycles, with an ignored restart mid-clear.
        run_clear(12'h0F0, 1'b1, -1, busy_n, done_n, pw_hits);
        check("clrA_busy_cycles", busy_n, 19210);
        check("clrA_done_pulses", done_n, 1);
        check("clrA_pw_ready_during_busy", pw_hits, 0);
        check("clrA_mem_first", mem[0], 12'h0F0);
        check("clrA_mem_last", mem[DEPTH-1], 12'h0F0);
        check("clrA_mem_all_bad", mem_mismatches(0, DEPTH-1, 12'h0F0), 0);

        // Reset when clr_ptr reaches 500.
        run_clear(12'h00F, 1'b0, 500, busy_n, done_n, pw_hits);
        check("clrB_busy_cycles", busy_n, 501);
        check("clrB_done_pulses", done_n, 0);
        check("clrB_after_busy", clr_busy, 0);
        check("clrB_low_bad", mem_mismatches(0, 499, 12'h00F), 0);
        check("clrB_high_bad", mem_mismatches(500, DEPTH-1, 12'h0F0), 0);

        clr_start = 1'b1; clr_color = 12'h333;
        tick;
        clr_start = 1'b0;
        check("restart_busy", clr_busy, 1);
        check("restart_ram_a", ram_a, 0);
        check("restart_ram_we", ram_we, 1);
        check("restart_ram_wd", ram_wd, 12'h333);
        reset = 1'b1;
        #1;
        check("restart_reset_we", ram_we, 0);
        tick;
        reset = 1'b0;
        check("restart_reset_busy", clr_busy, 0);

        // Unstalled clear with paint requests held off for the whole run.
        run_clear(12'hA5A, 1'b0, -1, busy_n, done_n, pw_hits);
        check("clrC_busy_cycles", busy_n, DEPTH);
        check("clrC_done_pulses", done_n, 1);
        check("clrC_pw_ready_during_busy", pw_hits, 0);
        check("clrC_mem_all_bad", mem_mismatches(0, DEPTH-1, 12'hA5A), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
